// File: rtl/alu_cmd_issuer_if.sv
// Command and result handshake bundle for alu_cmd_issuer; slave = issuer, master = producer/consumer.
// res_zero exists only when ALU_ZERO_FLAG_EN is defined.
interface alu_cmd_issuer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic [3:0] cmd_sel;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       res_cout;
  logic [3:0] res_sel;
`ifdef ALU_ZERO_FLAG_EN
  logic       res_zero;

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_sel, res_ready,
    input  cmd_ready, res_valid, res_data, res_cout, res_sel, res_zero
  );
  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_sel, res_ready,
    output cmd_ready, res_valid, res_data, res_cout, res_sel, res_zero
  );
`else
  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_sel, res_ready,
    input  cmd_ready, res_valid, res_data, res_cout, res_sel
  );
  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_sel, res_ready,
    output cmd_ready, res_valid, res_data, res_cout, res_sel
  );
`endif
endinterface

// File: rtl/alu_cmd_issuer.sv
// FIFO-buffered ALU command issue: result valid SETTLE_CYCLES+1 cycles after a command reaches an idle block.
// cmd_ready drops only on FIFO full; a result holds until res_ready. Defining ALU_ZERO_FLAG_EN adds res_zero.
module alu_cmd_issuer #(
  parameter int FIFO_DEPTH    = 4,
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_cmd_issuer_if.slave  io,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [3:0]       alu_sel,
  input  logic [7:0]       alu_out,
  input  logic             alu_cout,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_CYCLES - 1);

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] sel;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

  cmd_t           mem_q [FIFO_DEPTH];
  cmd_t           head;
  logic [AW:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic           fifo_empty, fifo_full, fifo_push, fifo_pop;

  state_t         state_q, state_d;
  logic [SCW-1:0] settle_q, settle_d;
  logic [7:0]     alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [3:0]     alu_sel_q, alu_sel_d;
  logic [7:0]     res_data_q, res_data_d;
  logic           res_cout_q, res_cout_d;
  logic [3:0]     res_sel_q, res_sel_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;
`ifdef ALU_ZERO_FLAG_EN
  logic           res_zero_q, res_zero_d;
`endif

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign fifo_push  = io.cmd_valid && io.cmd_ready;
  assign head       = mem_q[rd_ptr_q[AW-1:0]];
  assign wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, fifo_push};
  assign rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, fifo_pop};

  always_ff @(posedge clk) begin
    if (fifo_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= '{a: io.cmd_a, b: io.cmd_b, sel: io.cmd_sel};
    end
  end

  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    fifo_pop   = 1'b0;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_sel_d  = alu_sel_q;
    res_data_d = res_data_q;
    res_cout_d = res_cout_q;
    res_sel_d  = res_sel_q;
    op_count_d = op_count_q;
`ifdef ALU_ZERO_FLAG_EN
    res_zero_d = res_zero_q;
`endif
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        settle_d = settle_q + 1'b1;
        if (settle_q == SETTLE_LAST) begin
          res_data_d = alu_out;
          res_cout_d = alu_cout;
          res_sel_d  = alu_sel_q;
`ifdef ALU_ZERO_FLAG_EN
          res_zero_d = (alu_out == 8'h00);
`endif
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (io.res_ready) begin
          op_count_d = op_count_q + 1'b1;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            state_d  = ISSUE;
          end else begin
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Every pop starts a fresh settle window with the popped operands.
    if (fifo_pop) begin
      alu_a_d   = head.a;
      alu_b_d   = head.b;
      alu_sel_d = head.sel;
      settle_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      state_q    <= IDLE;
      settle_q   <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_sel_q  <= '0;
      res_data_q <= '0;
      res_cout_q <= 1'b0;
      res_sel_q  <= '0;
      op_count_q <= '0;
`ifdef ALU_ZERO_FLAG_EN
      res_zero_q <= 1'b0;
`endif
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      state_q    <= state_d;
      settle_q   <= settle_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_sel_q  <= alu_sel_d;
      res_data_q <= res_data_d;
      res_cout_q <= res_cout_d;
      res_sel_q  <= res_sel_d;
      op_count_q <= op_count_d;
`ifdef ALU_ZERO_FLAG_EN
      res_zero_q <= res_zero_d;
`endif
    end
  end

  assign io.cmd_ready = rst_n && !fifo_full;
  assign io.res_valid = (state_q == HOLD);
  assign io.res_data  = res_data_q;
  assign io.res_cout  = res_cout_q;
  assign io.res_sel   = res_sel_q;
`ifdef ALU_ZERO_FLAG_EN
  assign io.res_zero  = res_zero_q;
`endif
  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_sel  = alu_sel_q;
  assign busy     = (state_q != IDLE) || !fifo_empty;
  assign op_count = op_count_q;

endmodule

// File: doc/alu_cmd_issuer.md
Name: alu_cmd_issuer

Overview:
Command-issue stage sitting directly upstream of the team's 8-bit combinational ALU (A, B, 4-bit Sel in; 8-bit result and carry-out back).
- Buffers operand/opcode commands in a small FIFO.
- Drives registered operands onto the ALU and waits a programmable settle time.
- Captures the ALU result and carry, then presents them on a valid/ready result port.
- Replaces the free-running, time-delay stimulus the ALU currently gets with a proper handshaked datapath.

Parameters:
FIFO_DEPTH, 4, command FIFO entries; power of 2, minimum 2.
SETTLE_CYCLES, 1, cycles the ALU inputs are held before the result is sampled; minimum 1.
CNT_W, 16, width of the completed-operation counter.

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  synchronous active-low reset.
cmd_valid  input  1  command present.
cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
cmd_a  input  8  operand A.
cmd_b  input  8  operand B.
cmd_sel  input  4  ALU opcode.
alu_a  output  8  registered operand A to ALU.
alu_b  output  8  registered operand B to ALU.
alu_sel  output  4  registered opcode to ALU.
alu_out  input  8  ALU result (combinational from alu_a/alu_b/alu_sel).
alu_cout  input  1  ALU carry-out.
res_valid  output  1  result available.
res_ready  input  1  consumer accepts the result.
res_data  output  8  captured ALU result.
res_cout  output  1  captured carry.
res_sel  output  4  opcode that produced the result (tag).
busy  output  1  high when the FSM is not in IDLE or the FIFO is non-empty.
op_count  output  CNT_W  number of results handed off; wraps modulo 2^CNT_W.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low (rst_n sampled on the rising edge of clk).
- Reset values: FIFO empty; FSM = IDLE; alu_a/alu_b/alu_sel = 0; res_valid = 0; res_data/res_cout/res_sel = 0; op_count = 0; busy = 0. cmd_ready = 0 while rst_n = 0, else !fifo_full.
- Reset mid-operation: any in-flight or queued command is discarded with no result produced; the first cycle after release behaves as post-reset IDLE.
- FIFO push: on cmd_valid && cmd_ready, write {cmd_a, cmd_b, cmd_sel}.
  - No write-through when full: cmd_ready depends only on full, even if a pop happens in the same cycle.
  - Simultaneous push and pop on a non-full, non-empty FIFO are both performed.
  - A push into an empty FIFO is visible to the FSM on the next cycle.
- FSM states:
  - IDLE: if FIFO non-empty, pop and load alu_a/alu_b/alu_sel, clear the settle counter, go to ISSUE. Otherwise stay.
  - ISSUE: hold the ALU inputs and increment the settle counter. On the cycle where counter == SETTLE_CYCLES-1, register alu_out→res_data, alu_cout→res_cout, alu_sel→res_sel, set res_valid = 1, go to HOLD.
  - HOLD: res_valid = 1; res_data/res_cout/res_sel stay stable while res_ready = 0. On res_ready:
    - op_count += 1.
    - If FIFO non-empty: pop, load ALU inputs, clear res_valid, go to ISSUE (back-to-back).
    - Else: clear res_valid, go to IDLE.
- alu_* registers change only on a pop; they retain their last values in IDLE and HOLD.
- Latency: command accepted at edge N into an empty, idle block → ALU inputs valid after N+1 → res_valid high after edge N+1+SETTLE_CYCLES.
- Throughput with res_ready tied high: one result per SETTLE_CYCLES+1 cycles.
- Capacity: FIFO_DEPTH entries plus one command held in ISSUE/HOLD. Default configuration accepts 5 commands before stalling when res_ready = 0.
- Data widths: all 8-bit, no truncation or extension. Sel is passed through opaquely, so all 16 opcodes are legal.

Optional Feature:
Macro ALU_ZERO_FLAG_EN.
- Defined: adds output port res_zero (1 bit), registered together with res_data, = (alu_out == 8'h00). It resets to 0 and is stable in HOLD.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Single op, reset 0→1 then cmd A=0x0A B=0x02 sel=0x0 (add), res_ready=1 → alu_a=0x0A alu_b=0x02 alu_sel=0 one cycle after acceptance; res_valid two cycles after acceptance with res_data=0x0C, res_cout=0, res_sel=0; op_count=1.
- Carry/zero: A=0xF6 B=0x0A sel=0x0 → res_data=0x00, res_cout=1; res_zero=1 when ALU_ZERO_FLAG_EN is defined.
- Fill/backpressure: res_ready=0, cmd_valid held high with 7 distinct cmds → exactly 5 accepted, cmd_ready=0 from the 6th. Then res_ready=1 → 5 results in acceptance order, cmd_ready returns high after the first FIFO pop.
- Hold stability: res_ready=0 for 3 cycles during HOLD → res_data/res_cout/res_sel unchanged, op_count unchanged; pulse res_ready → op_count increments by exactly 1.
- Opcode sweep: A=0x0A B=0x02, sel=0..15 back-to-back, res_ready=1 → 16 results, res_sel=0..15 in order matching the ALU reference model, one result every 2 cycles (SETTLE_CYCLES=1); repeat with SETTLE_CYCLES=3 → every 4 cycles.
- Reset mid-op: 3 cmds queued, rst_n=0 for 1 cycle during ISSUE → all outputs at reset values, no res_valid afterwards, cmd_ready=1 the cycle after release; a new cmd completes normally.
